// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the two byte-source request ports, the TX engine handshake and the
// grant status. "slave" is the arbiter's view; "master" is the environment's view.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_last;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_last;
  logic                  req1_ready;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_busy;
  logic                  grant_valid;
  logic                  grant_id;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  tx_busy,
    output req0_ready, req1_ready,
    output tx_start, tx_data,
    output grant_valid, grant_id
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output tx_busy,
    input  req0_ready, req1_ready,
    input  tx_start, tx_data,
    input  grant_valid, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX engine between two byte sources. Ownership is granted per
// frame (bytes up to last=1), round-robin between frames, and is also released
// on a burst limit or when the owner stalls too long in ISSUE.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam int ICW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [BCW-1:0] BURST_LIM = BCW'(MAX_BURST);
  localparam logic [ICW-1:0] IDLE_LIM  = ICW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic                  grant_valid_q, grant_valid_d;
  logic                  grant_id_q, grant_id_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  last_q, last_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ICW-1:0]        idle_cnt_q, idle_cnt_d;

  logic                  g_valid;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_last;
  logic                  rel;
  logic [BCW-1:0]        byte_inc;
  logic [ICW-1:0]        idle_inc;

  function automatic logic [BCW-1:0] sat_inc_byte(input logic [BCW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ICW-1:0] sat_inc_idle(input logic [ICW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State and datapath registers; everything returns to idle values on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 1'b0;
      rr_ptr_q      <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      last_q        <= 1'b0;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  // Next-state logic: grant selection, byte issue, engine handshake, release.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    tx_start_d    = tx_start_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    byte_cnt_d    = byte_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    rel           = 1'b0;
    g_valid       = grant_id_q ? bus.req1_valid : bus.req0_valid;
    g_data        = grant_id_q ? bus.req1_data  : bus.req0_data;
    g_last        = grant_id_q ? bus.req1_last  : bus.req0_last;
    byte_inc      = sat_inc_byte(byte_cnt_q);
    idle_inc      = sat_inc_idle(idle_cnt_q);

    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // Contention is settled by rr_ptr; a lone requester wins outright.
          grant_id_d    = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
          grant_valid_d = 1'b1;
          byte_cnt_d    = '0;
          idle_cnt_d    = '0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (g_valid) begin
          tx_data_d  = g_data;
          tx_start_d = 1'b1;
          last_d     = g_last;
          byte_cnt_d = byte_inc;
          state_d    = WAIT_ACK;
        end else if (IDLE_TIMEOUT != 0 && idle_inc == IDLE_LIM) begin
          rel = 1'b1;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q || (MAX_BURST != 0 && byte_cnt_q == BURST_LIM)) begin
            rel = 1'b1;
          end else begin
            idle_cnt_d = '0;
            state_d    = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Releasing hands priority to the other port for the next contention.
    if (rel) begin
      state_d       = IDLE;
      grant_valid_d = 1'b0;
      rr_ptr_d      = ~grant_id_q;
    end
  end

  assign bus.req0_ready  = (state_q == ISSUE) && !grant_id_q;
  assign bus.req1_ready  = (state_q == ISSUE) &&  grant_id_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;

endmodule
